rom_load_sequencer: RTL and testbench



---
 rtl/rom_load_sequencer.sv | 95 +++++++++
 tb/tb_rom_load_sequencer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/rom_load_sequencer.sv
// rom_load_sequencer: routes HPS download bytes to ROM regions and sequences core reset
module rom_load_sequencer #(
  parameter int          HOLD_CYCLES = 1024,
  parameter logic [15:0] CPU_END     = 16'h7FFF,
  parameter logic [15:0] GFX_END     = 16'hBFFF,
  parameter logic [15:0] PROM_END    = 16'hC2FF
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        dn_download,
  input  logic        dn_wr,
  input  logic [24:0] dn_addr,
  input  logic [7:0]  dn_data,
  input  logic        user_reset,
  output logic        core_reset,
  output logic        wr_cpu,
  output logic        wr_gfx,
  output logic        wr_prom,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic [16:0] byte_count,
  output logic [7:0]  checksum,
  output logic        load_done,
  output logic        overflow
);
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_V = CW'(HOLD_CYCLES);

  typedef enum logic [1:0] {HOLD, LOAD, RUN} state_t;

  state_t        r_state, w_nxt;
  logic [CW-1:0] r_cnt;
  logic          w_acc, w_clr, w_end, w_reload, w_hi_ok, w_cpu, w_gfx, w_prom, w_in, w_inc;
  logic [15:0]   w_a, w_off;
  logic [16:0]   w_bc_base;
  logic [7:0]    w_cs_base;

  // Next-state, reload and region decode of the current download byte
  always_comb begin
    w_acc     = dn_download & dn_wr;
    w_clr     = dn_download & (r_state != LOAD);
    w_end     = (r_state == LOAD) & ~dn_download;
    w_reload  = w_end | (~dn_download & user_reset & (r_state != LOAD));
    w_nxt     = dn_download ? LOAD : w_reload ? HOLD :
                (r_state == HOLD) ? ((r_cnt == CW'(1)) ? RUN : HOLD) : r_state;
    w_a       = dn_addr[15:0];
    w_hi_ok   = (dn_addr[24:16] == 9'd0);
    w_cpu     = w_hi_ok & (w_a <= CPU_END);
    w_gfx     = w_hi_ok & (w_a > CPU_END) & (w_a <= GFX_END);
    w_prom    = w_hi_ok & (w_a > GFX_END) & (w_a <= PROM_END);
    w_in      = w_cpu | w_gfx | w_prom;
    w_off     = w_cpu ? w_a : w_gfx ? (w_a - CPU_END - 16'd1) : (w_a - GFX_END - 16'd1);
    w_bc_base = w_clr ? 17'd0 : byte_count;
    w_cs_base = w_clr ? 8'd0 : checksum;
    w_inc     = w_acc & w_in & ~(&w_bc_base);
  end

  // Sequencer state, hold counter and core reset registered from the next state
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state    <= HOLD;
      r_cnt      <= HOLD_V;
      core_reset <= 1'b1;
    end else begin
      r_state    <= w_nxt;
      r_cnt      <= w_reload ? HOLD_V : (r_state == HOLD) ? r_cnt - CW'(1) : r_cnt;
      core_reset <= (w_nxt != RUN);
    end
  end

  // Write strobes, region-local address/data and load statistics
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_cpu     <= 1'b0;
      wr_gfx     <= 1'b0;
      wr_prom    <= 1'b0;
      wr_addr    <= 16'd0;
      wr_data    <= 8'd0;
      byte_count <= 17'd0;
      checksum   <= 8'd0;
      load_done  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      wr_cpu     <= w_acc & w_cpu;
      wr_gfx     <= w_acc & w_gfx;
      wr_prom    <= w_acc & w_prom;
      wr_addr    <= (w_acc & w_in) ? w_off : wr_addr;
      wr_data    <= (w_acc & w_in) ? dn_data : wr_data;
      byte_count <= w_bc_base + {16'd0, w_inc};
      checksum   <= w_cs_base + ((w_acc & w_in) ? dn_data : 8'd0);
      load_done  <= w_clr ? 1'b0 : w_end ? 1'b1 : load_done;
      overflow   <= (~w_clr & overflow) | (w_acc & ~w_in);
    end
  end
endmodule

// File: tb/tb_rom_load_sequencer.sv
// tb_rom_load_sequencer: directed checks of routing, counters and reset sequencing
module tb_rom_load_sequencer;
  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        dn_download = 1'b0;
  logic        dn_wr = 1'b0;
  logic [24:0] dn_addr = '0;
  logic [7:0]  dn_data = '0;
  logic        user_reset = 1'b0;
  logic        core_reset, wr_cpu, wr_gfx, wr_prom, load_done, overflow;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data, checksum;
  logic [16:0] byte_count;
  int          total = 0;
  int          bad = 0;

  rom_load_sequencer #(.HOLD_CYCLES(16)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .dn_download(dn_download), .dn_wr(dn_wr),
    .dn_addr(dn_addr), .dn_data(dn_data), .user_reset(user_reset),
    .core_reset(core_reset), .wr_cpu(wr_cpu), .wr_gfx(wr_gfx), .wr_prom(wr_prom),
    .wr_addr(wr_addr), .wr_data(wr_data), .byte_count(byte_count), .checksum(checksum),
    .load_done(load_done), .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [24:0] a, input logic [7:0] d);
    dn_wr = 1'b1;
    dn_addr = a;
    dn_data = d;
    tick();
    dn_wr = 1'b0;
  endtask

  task automatic hold_run(input string tag);
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk(tag, {31'd0, core_reset}, {31'd0, i < 16});
    end
  endtask

  initial begin
    repeat (5) tick();
    chk("rst_core", {31'd0, core_reset}, 32'd1);
    chk("rst_strb", {29'd0, wr_cpu, wr_gfx, wr_prom}, 32'd0);
    chk("rst_addr", {16'd0, wr_addr}, 32'd0);
    chk("rst_cnt", {15'd0, byte_count}, 32'd0);
    RESET_N = 1'b1;
    hold_run("pwrup_core");
    chk("pwrup_stat", {23'd0, checksum, load_done}, 32'd0);

    dn_download = 1'b1;
    wr(25'h0000, 8'hA5);
    chk("cpu_strb", {29'd0, wr_cpu, wr_gfx, wr_prom}, 32'b100);
    chk("cpu_ad", {8'd0, wr_addr, wr_data}, 32'h0000A5);
    chk("load_core", {31'd0, core_reset}, 32'd1);
    wr(25'h8001, 8'h3C);
    chk("gfx_strb", {29'd0, wr_cpu, wr_gfx, wr_prom}, 32'b010);
    chk("gfx_ad", {8'd0, wr_addr, wr_data}, 32'h00013C);
    wr(25'hC005, 8'h11);
    chk("prom_strb", {29'd0, wr_cpu, wr_gfx, wr_prom}, 32'b001);
    chk("prom_ad", {8'd0, wr_addr, wr_data}, 32'h000511);
    wr(25'hD000, 8'h77);
    chk("ovf_strb", {29'd0, wr_cpu, wr_gfx, wr_prom}, 32'd0);
    tick();
    chk("t2_cnt", {15'd0, byte_count}, 32'd3);
    chk("t2_sum", {24'd0, checksum}, 32'hF2);
    chk("t2_ovf", {30'd0, overflow, load_done}, 32'b10);

    dn_download = 1'b0;
    tick();
    chk("end_done", {30'd0, load_done, core_reset}, 32'b11);
    hold_run("end_core");
    chk("end_keep", {14'd0, byte_count, overflow}, {14'd0, 17'd3, 1'b1});

    dn_download = 1'b1;
    for (int i = 0; i < 256; i++) begin
      wr(25'(i), 8'(i));
      if (i == 0) chk("b2b_first", {14'd0, byte_count, overflow, load_done}, {14'd0, 17'd1, 2'b00});
    end
    tick();
    chk("b2b_cnt", {15'd0, byte_count}, 32'd256);
    chk("b2b_sum", {24'd0, checksum}, 32'h80);
    dn_download = 1'b0;
    tick();
    chk("b2b_done", {31'd0, load_done}, 32'd1);
    hold_run("b2b_core");

    user_reset = 1'b1;
    tick();
    chk("ur_rise", {31'd0, core_reset}, 32'd1);
    repeat (2) tick();
    user_reset = 1'b0;
    hold_run("ur_core");
    chk("ur_done", {31'd0, load_done}, 32'd1);

    dn_download = 1'b1;
    wr(25'h0010, 8'h01);
    wr(25'h0011, 8'h02);
    dn_download = 1'b0;
    tick();
    chk("rs_pre", {14'd0, byte_count, load_done}, {14'd0, 17'd2, 1'b1});
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rs_hold", {31'd0, core_reset}, 32'd1);
    end
    dn_download = 1'b1;
    tick();
    chk("rs_core", {31'd0, core_reset}, 32'd1);
    chk("rs_clr", {7'd0, byte_count, checksum}, 32'd0);
    chk("rs_done", {31'd0, load_done}, 32'd0);

    for (int i = 0; i < 10; i++) wr(25'(i), 8'h01);
    chk("ab_pre", {15'd0, byte_count}, 32'd10);
    RESET_N = 1'b0;
    #1;
    chk("ab_cnt", {15'd0, byte_count}, 32'd0);
    chk("ab_stat", {30'd0, load_done, core_reset}, 32'b01);
    dn_download = 1'b0;
    tick();
    RESET_N = 1'b1;
    hold_run("ab_core");
    chk("ab_done", {31'd0, load_done}, 32'd0);
    wr(25'h0000, 8'hFF);
    chk("ign_strb", {29'd0, wr_cpu, wr_gfx, wr_prom}, 32'd0);
    chk("ign_cnt", {7'd0, byte_count, checksum}, 32'd0);
    chk("ign_data", {24'd0, wr_data}, 32'd0);

    dn_download = 1'b1;
    wr(25'h7FFF, 8'h01);
    chk("bnd_cpu", {13'd0, wr_cpu, wr_gfx, wr_prom, wr_addr}, {13'd0, 3'b100, 16'h7FFF});
    wr(25'hBFFF, 8'h02);
    chk("bnd_gfx", {13'd0, wr_cpu, wr_gfx, wr_prom, wr_addr}, {13'd0, 3'b010, 16'h3FFF});
    wr(25'hC2FF, 8'h03);
    chk("bnd_prom", {13'd0, wr_cpu, wr_gfx, wr_prom, wr_addr}, {13'd0, 3'b001, 16'h02FF});
    wr(25'hC300, 8'h40);
    chk("bnd_over", {29'd0, wr_cpu, wr_gfx, wr_prom}, 32'd0);
    wr(25'h10000, 8'h40);
    chk("bnd_hi", {29'd0, wr_cpu, wr_gfx, wr_prom}, 32'd0);
    chk("bnd_stat", {6'd0, byte_count, checksum, overflow}, {6'd0, 17'd3, 8'h06, 1'b1});
    dn_download = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
